// File: rtl/meter_display_scheduler.sv
// -----------------------------------------------------------------------------
// meter_display_scheduler
//
// Purpose:
//   Time-multiplexes the parking meter's four BCD digits onto one shared
//   7-segment bus. The block scans the digits round-robin and copies a
//   snapshot of the digits and blink mode at each frame boundary, so a frame
//   is never torn. It gates the display for the slow/fast blink warnings and
//   can blank leading zeros.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   val1..val4   BCD digits, val1 = thousands .. val4 = units
//   blink_mode   0 steady, 1 slow blink, 2 fast blink, 3 blank
//   led_seg      active-low segments, bit0 = a .. bit6 = g
//   a1..a4       active-low anode selects for val1..val4
//   digit_sel    slot index currently driven on the bus (0 = val1)
//   frame_start  one-cycle pulse at the start of each scan frame
//
// Parameters:
//   SCAN_DIV     clk cycles per digit slot (>= 1)
//   BLINK_DIV    clk cycles per fast-blink half-period (>= 1)
//   LZB          1 enables leading-zero blanking
// -----------------------------------------------------------------------------
module meter_display_scheduler #(
  parameter int SCAN_DIV  = 1,
  parameter int BLINK_DIV = 50,
  parameter int LZB       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val1,
  input  logic [3:0] val2,
  input  logic [3:0] val3,
  input  logic [3:0] val4,
  input  logic [1:0] blink_mode,
  output logic [6:0] led_seg,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       a4,
  output logic [1:0] digit_sel,
  output logic       frame_start
);

  // A divide-by-one counter still needs one bit so that the code stays legal.
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    MODE_STEADY = 2'd0,
    MODE_SLOW   = 2'd1,
    MODE_FAST   = 2'd2,
    MODE_BLANK  = 2'd3
  } blink_mode_e;

  // Scan state
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         slot;

  // Frame snapshot; nibble k holds the digit shown in slot k.
  logic [3:0][3:0]    shadow_val;
  blink_mode_e        shadow_mode;

  // Blink timebase
  logic [BLINK_W-1:0] blink_cnt;
  logic               fast_ph;
  logic               slow_ph;

  // Registered outputs
  logic [6:0]         seg_q;
  logic [3:0]         anode_q;
  logic [1:0]         sel_q;
  logic               frame_q;

  // Next-output values, computed from the current slot and snapshot
  logic               scan_last;
  logic               frame_wrap;
  logic               blink_last;
  logic [3:0]         cur_digit;
  logic               visible;
  logic               blanked;
  logic [6:0]         seg_d;
  logic [3:0]         anode_d;

  // Active-low {g..a} pattern; non-decimal codes show a dash (segment g only).
  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    logic [6:0] seg;
    unique case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  assign scan_last  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_last && (slot == 2'd3);
  assign blink_last = (blink_cnt == BLINK_LAST);

  // NOTE: every signal is given a default at the top of a combinational block,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    cur_digit = shadow_val[slot];
    visible   = 1'b0;
    blanked   = 1'b0;
    seg_d     = SEG_OFF;
    anode_d   = 4'b1111;

    unique case (shadow_mode)
      MODE_STEADY: visible = 1'b1;
      MODE_SLOW:   visible = slow_ph;
      MODE_FAST:   visible = fast_ph;
      MODE_BLANK:  visible = 1'b0;
      default:     visible = 1'b0;
    endcase

    // A zero digit is a leading zero only when every more significant digit
    // is also zero. The units digit is always shown.
    if (LZB != 0) begin
      unique case (slot)
        2'd0:    blanked = (shadow_val[0] == 4'd0);
        2'd1:    blanked = (shadow_val[0] == 4'd0) && (shadow_val[1] == 4'd0);
        2'd2:    blanked = (shadow_val[0] == 4'd0) && (shadow_val[1] == 4'd0)
                           && (shadow_val[2] == 4'd0);
        default: blanked = 1'b0;
      endcase
    end

    if (visible && !blanked) begin
      anode_d[slot] = 1'b0;
      seg_d         = decode_bcd(cur_digit);
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge and the order of statements does
  // not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      slot        <= 2'd0;
      // NOTE: the snapshot is only sixteen flops. It is reset so that the
      // first frame after reset shows defined zeros and not stale digits.
      shadow_val  <= '0;
      shadow_mode <= MODE_STEADY;
      blink_cnt   <= '0;
      fast_ph     <= 1'b1;
      slow_ph     <= 1'b1;
      seg_q       <= SEG_OFF;
      anode_q     <= 4'b1111;
      sel_q       <= 2'd0;
      frame_q     <= 1'b0;
    end else begin
      // Slot scan
      if (scan_last) begin
        scan_cnt <= '0;
        slot     <= slot + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      // Take the snapshot as the slot wraps back to 0, so that slot 0 of the
      // new frame already uses the new values.
      if (frame_wrap) begin
        shadow_val  <= {val4, val3, val2, val1};
        shadow_mode <= blink_mode_e'(blink_mode);
      end

      // Free-running blink timebase. slow_ph toggles on every second fast_ph
      // toggle, which is the one where fast_ph goes from 0 back to 1.
      if (blink_last) begin
        blink_cnt <= '0;
        fast_ph   <= ~fast_ph;
        if (!fast_ph) begin
          slow_ph <= ~slow_ph;
        end
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      // Select, anodes and segments are updated on the same edge, so they
      // always describe the same slot.
      seg_q   <= seg_d;
      anode_q <= anode_d;
      sel_q   <= slot;
      frame_q <= frame_wrap;
    end
  end

  assign led_seg     = seg_q;
  assign a1          = anode_q[0];
  assign a2          = anode_q[1];
  assign a3          = anode_q[2];
  assign a4          = anode_q[3];
  assign digit_sel   = sel_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_meter_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_meter_display_scheduler
//
// Two instances share the same stimulus:
//   dut_a: SCAN_DIV=1, BLINK_DIV=4, LZB=0
//   dut_b: SCAN_DIV=2, BLINK_DIV=3, LZB=1
// The reference model works from the number of clock edges since reset. It
// derives the slot and the blink phases with division, and it keeps a copy of
// the digits taken at every frame boundary.
// -----------------------------------------------------------------------------
module tb_meter_display_scheduler;

  localparam int SD_A = 1, BD_A = 4, LZ_A = 0;
  localparam int SD_B = 2, BD_B = 3, LZ_B = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] val1, val2, val3, val4;
  logic [1:0] blink_mode;

  logic [6:0] seg_a, seg_b;
  logic       a1_a, a2_a, a3_a, a4_a, a1_b, a2_b, a3_b, a4_b;
  logic [1:0] sel_a, sel_b;
  logic       fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  meter_display_scheduler #(.SCAN_DIV(SD_A), .BLINK_DIV(BD_A), .LZB(LZ_A)) dut_a (
    .clk(clk), .rst(rst), .val1(val1), .val2(val2), .val3(val3), .val4(val4),
    .blink_mode(blink_mode), .led_seg(seg_a), .a1(a1_a), .a2(a2_a), .a3(a3_a),
    .a4(a4_a), .digit_sel(sel_a), .frame_start(fs_a)
  );

  meter_display_scheduler #(.SCAN_DIV(SD_B), .BLINK_DIV(BD_B), .LZB(LZ_B)) dut_b (
    .clk(clk), .rst(rst), .val1(val1), .val2(val2), .val3(val3), .val4(val4),
    .blink_mode(blink_mode), .led_seg(seg_b), .a1(a1_b), .a2(a2_b), .a3(a3_b),
    .a4(a4_b), .digit_sel(sel_b), .frame_start(fs_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Segment patterns for each digit code, active-low {g..a}.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
            7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
            7'b0111111};
    return tbl[d];
  endfunction

  // Output expected after the edge that follows e edges since reset.
  function automatic void model_out(input int sd, input int bd, input int lzb, input int e,
                                    input logic [15:0] sh, input logic [1:0] md,
                                    output logic [6:0] seg, output logic [3:0] an,
                                    output logic [1:0] sel);
    int  slot;
    bit  fast, slow, vis, blank;
    logic [3:0] v [4];
    slot = (e / sd) % 4;
    fast = ((e / bd) % 2) == 0;
    slow = ((e / (2 * bd)) % 2) == 0;
    for (int k = 0; k < 4; k++) v[k] = sh[k*4 +: 4];
    case (md)
      2'd0:    vis = 1;
      2'd1:    vis = slow;
      2'd2:    vis = fast;
      default: vis = 0;
    endcase
    blank = 0;
    if (lzb != 0) begin
      if (slot == 0) blank = (v[0] == 0);
      if (slot == 1) blank = (v[0] == 0) && (v[1] == 0);
      if (slot == 2) blank = (v[0] == 0) && (v[1] == 0) && (v[2] == 0);
    end
    sel = 2'(slot);
    if (vis && !blank) begin
      an  = ~(4'b0001 << slot);
      seg = seg_of(v[slot]);
    end else begin
      an  = 4'hF;
      seg = 7'h7F;
    end
  endfunction

  // Reference model state, one set per instance
  int          e_a = 0, e_b = 0;
  logic [15:0] sh_a = '0, sh_b = '0;
  logic [1:0]  md_a = '0, md_b = '0;
  logic [6:0]  xs_a = 7'h7F, xs_b = 7'h7F;
  logic [3:0]  xa_a = 4'hF, xa_b = 4'hF;
  logic [1:0]  xd_a = '0, xd_b = '0;
  logic        xf_a = 0, xf_b = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      e_a = 0; sh_a = '0; md_a = '0; xs_a = 7'h7F; xa_a = 4'hF; xd_a = '0; xf_a = 0;
      e_b = 0; sh_b = '0; md_b = '0; xs_b = 7'h7F; xa_b = 4'hF; xd_b = '0; xf_b = 0;
    end else begin
      model_out(SD_A, BD_A, LZ_A, e_a, sh_a, md_a, xs_a, xa_a, xd_a);
      model_out(SD_B, BD_B, LZ_B, e_b, sh_b, md_b, xs_b, xa_b, xd_b);
      e_a++;
      e_b++;
      xf_a = (e_a % (4 * SD_A)) == 0;
      xf_b = (e_b % (4 * SD_B)) == 0;
      if (xf_a) begin sh_a = {val4, val3, val2, val1}; md_a = blink_mode; end
      if (xf_b) begin sh_b = {val4, val3, val2, val1}; md_b = blink_mode; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_seg",    32'(seg_a), 32'(xs_a));
      check("a_anodes", 32'({a4_a, a3_a, a2_a, a1_a}), 32'(xa_a));
      check("a_sel",    32'(sel_a), 32'(xd_a));
      check("a_frame",  32'(fs_a),  32'(xf_a));
      check("b_seg",    32'(seg_b), 32'(xs_b));
      check("b_anodes", 32'({a4_b, a3_b, a2_b, a1_b}), 32'(xa_b));
      check("b_sel",    32'(sel_b), 32'(xd_b));
      check("b_frame",  32'(fs_b),  32'(xf_b));
    end
  end

  function automatic logic [3:0] rnd_digit();
    // Zeros are favoured so that leading-zero blanking is exercised often.
    if ($urandom_range(0, 2) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1;
    val1 = 4'd1; val2 = 4'd2; val3 = 4'd3; val4 = 4'd4;
    blink_mode = 2'd0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Steady display of 1,2,3,4
    repeat (24) @(negedge clk);

    // Change val3 part-way through a frame; the frame in progress keeps 3.
    for (int i = 0; i < 8 && sel_a != 2'd1; i++) @(negedge clk);
    val3 = 4'd7;
    repeat (16) @(negedge clk);

    // Every blink mode, with the mode changed part-way through a frame
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      @(negedge clk);
      blink_mode = 2'(m);
      repeat (40) @(negedge clk);
    end
    blink_mode = 2'd0;

    // Leading-zero patterns and a non-decimal digit
    val1 = 4'd0; val2 = 4'd0; val3 = 4'd5; val4 = 4'd0;
    repeat (24) @(negedge clk);
    val3 = 4'd0;
    repeat (24) @(negedge clk);
    val1 = 4'd1; val2 = 4'hB; val3 = 4'd3;
    repeat (24) @(negedge clk);

    // Reset taken in the middle of a frame
    for (int i = 0; i < 8 && sel_a != 2'd2; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        val1 = rnd_digit(); val2 = rnd_digit(); val3 = rnd_digit(); val4 = rnd_digit();
      end
      if ($urandom_range(0, 30) == 0) blink_mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 250) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
